// File: rtl/param_updown_counter.sv
// Parameterised modulo-N up/down counter with parallel load, wrap/saturate boundary
// handling, a one-cycle wrap pulse and a sticky boundary-event flag.
module param_updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // MODULUS may be 2**WIDTH (up to 2**32), hence the 64-bit parameter types.
    localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_terminal;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_at_term;
    logic             w_boundary;
    logic             w_wrap_nxt;
    logic             w_ovf_nxt;

    assign w_terminal     = up_dn ? TOP_VAL : '0;
    assign w_at_term      = (r_count == w_terminal);
    assign w_boundary     = en & ~load & w_at_term;
    assign w_load_clamped = (64'(load_val) < MODULUS) ? load_val : TOP_VAL;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_ovf_nxt   = r_ovf & ~clr_ovf;

        if (load) begin
            w_count_nxt = w_load_clamped;
        end else if (en) begin
            if (w_at_term) begin
                // Boundary event: sticky flag wins over a same-cycle clear.
                w_ovf_nxt = 1'b1;
                if (!sat_mode) begin
                    w_count_nxt = up_dn ? '0 : TOP_VAL;
                    w_wrap_nxt  = 1'b1;
                end
            end else if (up_dn) begin
                w_count_nxt = r_count + WIDTH'(1);
            end else begin
                w_count_nxt = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            r_count <= INIT_VAL;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count = r_count;
    assign tc    = w_at_term;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;

    // w_boundary documents the event condition; it is folded into the next-state logic.
    logic w_unused;
    assign w_unused = w_boundary;

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL accept parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 The block SHALL accept parameter MODULUS, default 16, count range 0..MODULUS-1 (legal: 2..2**WIDTH).
REQ-003 The block SHALL accept parameter RESET_VAL, default 0, count value after reset (legal: < MODULUS).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port en  input  1  count enable; one step per clk edge while high.
REQ-007 The block SHALL have port up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val  input  WIDTH  value to load.
REQ-010 The block SHALL have port sat_mode  input  1  boundary mode; 1 = saturate, 0 = wrap.
REQ-011 The block SHALL have port clr_ovf  input  1  clears sticky ovf.
REQ-012 The block SHALL have port count  output  WIDTH  registered counter value.
REQ-013 The block SHALL have port tc  output  1  terminal-count indicator, combinational from count and up_dn.
REQ-014 The block SHALL have port wrap  output  1  registered one-cycle pulse, high the cycle after a wrap.
REQ-015 The block SHALL have port ovf  output  1  registered sticky boundary-event flag.

Function
REQ-016 Per-edge priority SHALL be: reset > load > en; with none active, count holds.
REQ-017 load SHALL set count = load_val when load_val < MODULUS, else count = MODULUS-1 (clamp); en is ignored that cycle.
REQ-018 en high with up_dn=1 and count < MODULUS-1 SHALL yield count+1 next cycle.
REQ-019 en high with up_dn=0 and count > 0 SHALL yield count-1 next cycle.
REQ-020 Terminal SHALL be MODULUS-1 when up_dn=1, 0 when up_dn=0; tc = (count == terminal), same cycle, independent of en.
REQ-021 A boundary event SHALL be en high, load low, count at terminal.
REQ-022 Boundary event with sat_mode=0 SHALL wrap count (MODULUS-1 -> 0 up, 0 -> MODULUS-1 down) and assert wrap for exactly the next cycle.
REQ-023 Boundary event with sat_mode=1 SHALL hold count at terminal and leave wrap low.
REQ-024 Every boundary event SHALL set ovf from the next cycle; ovf stays high until cleared.
REQ-025 clr_ovf SHALL clear ovf next cycle; a simultaneous boundary event SHALL win (ovf stays 1).
REQ-026 wrap SHALL be low in any cycle not directly following a wrap; consecutive wraps (MODULUS=2 style) SHALL keep wrap high each following cycle.
REQ-027 Direction change SHALL take effect on the same edge it is sampled; no pipeline latency.
REQ-028 Arithmetic SHALL never produce a value >= MODULUS; when MODULUS = 2**WIDTH, natural WIDTH-bit rollover SHALL match REQ-022.

Reset
REQ-029 reset high at a clk edge SHALL set count = RESET_VAL, wrap = 0, ovf = 0, overriding load, en and clr_ovf.
REQ-030 reset asserted mid-count SHALL take effect on the next edge only; no asynchronous path exists.
REQ-031 tc SHALL reflect RESET_VAL and up_dn immediately after reset.

Verification (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated)
REQ-032 reset 1 cycle, en=1, up_dn=1, sat_mode=0, 12 edges -> count 1..9, 0, 1, 2; tc high at 9; wrap high the cycle count=0; ovf=1 thereafter.
REQ-033 load=1, load_val=13 -> count=9; then en=1, up_dn=0, sat_mode=1, 11 edges -> 8..0 then holds 0; tc high at 0; wrap never high; ovf=1.
REQ-034 count=5, en=1, load=1, load_val=2 same edge -> count=2 (load wins, no step).
REQ-035 ovf=1, clr_ovf=1 with count=9, up, en=1 same edge -> count=0, wrap=1, ovf stays 1; next edge clr_ovf=1, count mid-range -> ovf=0.
REQ-036 count=7, en=1, reset=1 and load=1 same edge -> count=0, wrap=0, ovf=0.
REQ-037 WIDTH=4, MODULUS=16, RESET_VAL=3: reset -> count=3; up from 15 with en=1 -> 0 with wrap pulse.
